// File: rtl/tof_cal_mh.sv
// Multi-hit time-of-flight calculator: frame FSM, pipelined fine-code decode,
// coarse/fine subtraction with range check, and a result FIFO toward readout.
module tof_cal_mh #(
  parameter int FINE_W     = 16,
  parameter int COARSE_W   = 14,
  parameter int MAX_HITS   = 7,
  parameter int FIFO_DEPTH = 4,
  parameter int ENC_MODE   = 0,
  localparam int LOG   = $clog2(FINE_W),
  localparam int FL    = LOG + 1,
  localparam int TOF_W = COARSE_W + FL,
  localparam int HC_W  = $clog2(MAX_HITS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_start,
  input  logic [TOF_W-1:0]    range_max,
  input  logic                hit_valid,
  input  logic                hit_is_start,
  input  logic [FINE_W-1:0]   hit_fine,
  input  logic [COARSE_W-1:0] hit_coarse,
  output logic                tof_valid,
  input  logic                tof_ready,
  output logic [TOF_W-1:0]    tof_data,
  output logic [HC_W-1:0]     tof_idx,
  output logic                tof_sat,
  output logic [HC_W-1:0]     hit_cnt,
  output logic [2:0]          err_flags
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 1 + HC_W + TOF_W;

  // Handshake: a result leaves the FIFO on any cycle where tof_valid and
  // tof_ready are both high; tof_valid never depends on tof_ready.

  typedef enum logic [1:0] {IDLE, ARMED, RUN, FULL} state_t;
  state_t state, state_n;

  logic                acc_hit, err1_set, err2_set;
  logic [HC_W-1:0]     stop_cnt;
  logic [TOF_W-1:0]    rmax;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    acc_hit  = 1'b0;
    err1_set = 1'b0;
    err2_set = 1'b0;
    if (frame_start) begin
      state_n = ARMED;
    end else if (hit_valid) begin
      case (state)
        IDLE:  if (!hit_is_start) err1_set = 1'b1;
        ARMED: if (hit_is_start) begin
                 acc_hit = 1'b1;
                 state_n = RUN;
               end else begin
                 err1_set = 1'b1;
               end
        RUN:   if (hit_is_start) begin
                 err2_set = 1'b1;
               end else begin
                 acc_hit = 1'b1;
                 if (stop_cnt == HC_W'(MAX_HITS - 1)) state_n = FULL;
               end
        FULL:  err2_set = 1'b1;
        default: state_n = IDLE;
      endcase
    end
  end

  function automatic logic [FL-1:0] popcnt(input logic [FINE_W-1:0] f);
    logic [FL-1:0] n;
    n = '0;
    for (int i = 0; i < FINE_W; i++) n = n + FL'(f[i]);
    return n;
  endfunction

  // Stage 0 holds the edge vector; stages 1..LOG each halve the search window.
  logic                v_q   [0:LOG];
  logic                s_q   [0:LOG];
  logic [COARSE_W-1:0] c_q   [0:LOG];
  logic [HC_W-1:0]     i_q   [0:LOG];
  logic [FINE_W-1:0]   win_q [0:LOG];
  logic [LOG-1:0]      acc_q [0:LOG];
  logic                msb_q [0:LOG];
  logic [FL-1:0]       pc_q  [0:LOG];
  logic [FINE_W-1:0]   win_n [1:LOG];
  logic [LOG-1:0]      acc_n [1:LOG];

  always_comb begin
    logic [FINE_W-1:0] mask, upper;
    mask  = '0;
    upper = '0;
    for (int k = 1; k <= LOG; k++) begin
      mask  = {FINE_W{1'b1}} >> (FINE_W - (FINE_W >> k));
      upper = (win_q[k-1] >> (FINE_W >> k)) & mask;
      if (|upper) begin
        win_n[k] = upper;
        acc_n[k] = {acc_q[k-1][LOG-2:0], 1'b1};
      end else begin
        win_n[k] = win_q[k-1] & mask;
        acc_n[k] = {acc_q[k-1][LOG-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= LOG; k++) begin
        v_q[k]   <= 1'b0;
        s_q[k]   <= 1'b0;
        c_q[k]   <= '0;
        i_q[k]   <= '0;
        win_q[k] <= '0;
        acc_q[k] <= '0;
        msb_q[k] <= 1'b0;
        pc_q[k]  <= '0;
      end
    end else begin
      v_q[0]   <= acc_hit;
      s_q[0]   <= hit_is_start;
      c_q[0]   <= hit_coarse;
      i_q[0]   <= stop_cnt + HC_W'(1);
      win_q[0] <= hit_fine ^ {~hit_fine[0], hit_fine[FINE_W-1:1]};
      acc_q[0] <= '0;
      msb_q[0] <= hit_fine[FINE_W-1];
      pc_q[0]  <= popcnt(hit_fine);
      for (int k = 1; k <= LOG; k++) begin
        v_q[k]   <= v_q[k-1];
        s_q[k]   <= s_q[k-1];
        c_q[k]   <= c_q[k-1];
        i_q[k]   <= i_q[k-1];
        win_q[k] <= win_n[k];
        acc_q[k] <= acc_n[k];
        msb_q[k] <= msb_q[k-1];
        pc_q[k]  <= pc_q[k-1];
      end
    end
  end

  logic [LOG-1:0]        idx_f;
  logic [FL-1:0]         fine_d, ref_fine;
  logic [COARSE_W-1:0]   dc, ref_coarse;
  logic signed [TOF_W:0] t;
  logic                  sat;

  // Edge at the wrap position with MSB set means an all-ones code: fine = FINE_W.
  always_comb begin
    idx_f  = acc_q[LOG];
    fine_d = (ENC_MODE == 1) ? pc_q[LOG] : {msb_q[LOG] & (&idx_f), ~idx_f};
    dc     = c_q[LOG] - ref_coarse;
    t      = $signed({2'b00, dc, {LOG{1'b0}}})
           + $signed({{(COARSE_W+1){1'b0}}, fine_d})
           - $signed({{(COARSE_W+1){1'b0}}, ref_fine});
    sat    = t[TOF_W] | (t[TOF_W-1:0] > rmax);
  end

  logic             r_v, r_sat;
  logic [TOF_W-1:0] r_data;
  logic [HC_W-1:0]  r_idx;

  logic [EW-1:0]    mem [FIFO_DEPTH];
  logic [AW:0]      wp, rp;
  logic             full, empty, pop, push, ovf;
  logic [EW-1:0]    head;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign pop   = !empty && tof_ready;
  assign push  = r_v && (!full || pop);
  assign ovf   = r_v && full && !pop;
  assign head  = mem[rp[AW-1:0]];

  assign tof_valid = !empty;
  assign tof_data  = empty ? '0 : head[TOF_W-1:0];
  assign tof_idx   = empty ? '0 : head[TOF_W +: HC_W];
  assign tof_sat   = empty ? 1'b0 : head[EW-1];

  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= {r_sat, r_idx, r_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stop_cnt   <= '0;
      rmax       <= '0;
      ref_fine   <= '0;
      ref_coarse <= '0;
      r_v        <= 1'b0;
      r_sat      <= 1'b0;
      r_data     <= '0;
      r_idx      <= '0;
      wp         <= '0;
      rp         <= '0;
      hit_cnt    <= '0;
      err_flags  <= '0;
    end else begin
      r_v    <= v_q[LOG] && !s_q[LOG];
      r_sat  <= sat;
      r_data <= sat ? {TOF_W{1'b1}} : t[TOF_W-1:0];
      r_idx  <= i_q[LOG];
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      if (frame_start) begin
        stop_cnt   <= '0;
        rmax       <= range_max;
        ref_fine   <= '0;
        ref_coarse <= '0;
        hit_cnt    <= '0;
        err_flags  <= '0;
      end else begin
        if (acc_hit && !hit_is_start) stop_cnt <= stop_cnt + 1'b1;
        if (v_q[LOG] && s_q[LOG]) begin
          ref_fine   <= fine_d;
          ref_coarse <= c_q[LOG];
        end
        if (r_v && !r_sat) hit_cnt <= hit_cnt + 1'b1;
        err_flags <= err_flags | {err2_set, err1_set, ovf};
      end
    end
  end

endmodule

// File: tb/tb_tof_cal_mh.sv
// Directed bench for tof_cal_mh: one instance per fine-decode mode, driven in
// parallel, with hand-computed results checked through a single check task.
module tb_tof_cal_mh;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic [18:0] range_max;
  logic        hit_valid;
  logic        hit_is_start;
  logic [15:0] hit_fine;
  logic [13:0] hit_coarse;
  logic        tof_ready;

  logic        v0, v1, s0, s1;
  logic [18:0] d0, d1;
  logic [2:0]  i0, i1, hc0, hc1, e0, e1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  tof_cal_mh #(.ENC_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .range_max(range_max),
    .hit_valid(hit_valid), .hit_is_start(hit_is_start), .hit_fine(hit_fine),
    .hit_coarse(hit_coarse), .tof_valid(v0), .tof_ready(tof_ready),
    .tof_data(d0), .tof_idx(i0), .tof_sat(s0), .hit_cnt(hc0), .err_flags(e0)
  );

  tof_cal_mh #(.ENC_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .range_max(range_max),
    .hit_valid(hit_valid), .hit_is_start(hit_is_start), .hit_fine(hit_fine),
    .hit_coarse(hit_coarse), .tof_valid(v1), .tof_ready(tof_ready),
    .tof_data(d1), .tof_idx(i1), .tof_sat(s1), .hit_cnt(hc1), .err_flags(e1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic new_frame(input logic [18:0] rmax);
    frame_start = 1'b1;
    range_max   = rmax;
    cyc();
    frame_start = 1'b0;
  endtask

  task automatic hit(input logic st, input logic [15:0] f, input logic [13:0] c);
    hit_valid    = 1'b1;
    hit_is_start = st;
    hit_fine     = f;
    hit_coarse   = c;
    cyc();
    hit_valid = 1'b0;
  endtask

  task automatic wait_res(input string tag);
    int n;
    n = 0;
    while (!v0 && n < 20) begin
      cyc();
      n++;
    end
    check({tag, "_valid0"}, 32'(v0), 32'd1);
    check({tag, "_valid1"}, 32'(v1), 32'd1);
  endtask

  task automatic pop_chk(input string tag, input logic [18:0] ed0, input logic [18:0] ed1,
                         input logic [2:0] eidx, input logic esat);
    check({tag, "_valid"}, 32'(v0), 32'd1);
    check({tag, "_data0"}, 32'(d0), 32'(ed0));
    check({tag, "_data1"}, 32'(d1), 32'(ed1));
    check({tag, "_idx0"},  32'(i0), 32'(eidx));
    check({tag, "_idx1"},  32'(i1), 32'(eidx));
    check({tag, "_sat0"},  32'(s0), 32'(esat));
    check({tag, "_sat1"},  32'(s1), 32'(esat));
    tof_ready = 1'b1;
    cyc();
    tof_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int early;
    rst = 1'b1; frame_start = 1'b0; range_max = '0; hit_valid = 1'b0;
    hit_is_start = 1'b0; hit_fine = '0; hit_coarse = '0; tof_ready = 1'b0;
    idle(2);
    rst = 1'b0;
    cyc();
    check("rst_valid", 32'(v0 | v1), 32'd0);
    check("rst_data",  32'(d0 | d1), 32'd0);
    check("rst_cnt",   32'(hc0 | hc1), 32'd0);
    check("rst_err",   32'(e0 | e1), 32'd0);

    // Basic: fine 8 -> 12, coarse 10 -> 12, STOP right after START; latency 6
    new_frame(19'd1000);
    hit(1'b1, 16'hFF00, 14'd10);
    hit(1'b0, 16'hFFF0, 14'd12);
    early = 0;
    for (int i = 0; i < 5; i++) begin
      if (v0 || v1) early = 1;
      cyc();
    end
    check("lat_early", 32'(early), 32'd0);
    cyc();
    check("lat_on_time", 32'(v0 & v1), 32'd1);
    check("basic_cnt0", 32'(hc0), 32'd1);
    check("basic_cnt1", 32'(hc1), 32'd1);
    pop_chk("basic", 19'd36, 19'd36, 3'd1, 1'b0);
    check("basic_empty", 32'(v0 | v1), 32'd0);

    // Coarse wrap: 16383 -> 1 is 2 coarse ticks
    new_frame(19'd1000);
    hit(1'b1, 16'hFF00, 14'd16383);
    hit(1'b0, 16'hFF00, 14'd1);
    wait_res("wrap");
    pop_chk("wrap", 19'd32, 19'd32, 3'd1, 1'b0);

    // Negative, just-over-range and exactly-at-range results
    new_frame(19'd1000);
    hit(1'b1, 16'hFFF0, 14'd5);
    hit(1'b0, 16'hFF00, 14'd5);
    hit(1'b0, 16'hF800, 14'd68);
    hit(1'b0, 16'hF000, 14'd68);
    idle(10);
    check("range_cnt0", 32'(hc0), 32'd1);
    check("range_cnt1", 32'(hc1), 32'd1);
    pop_chk("neg",   19'h7FFFF, 19'h7FFFF, 3'd1, 1'b1);
    pop_chk("over",  19'h7FFFF, 19'h7FFFF, 3'd2, 1'b1);
    pop_chk("limit", 19'd1000,  19'd1000,  3'd3, 1'b0);

    // frame_start wins over a same-cycle START; the later STOP then sees no START
    new_frame(19'd1000);
    frame_start = 1'b1;
    hit(1'b1, 16'hFF00, 14'd0);
    frame_start = 1'b0;
    hit(1'b0, 16'hFF00, 14'd1);
    idle(10);
    check("prio_err0", 32'(e0), 32'd2);
    check("prio_err1", 32'(e1), 32'd2);
    check("prio_nores", 32'(v0 | v1), 32'd0);

    // Overflow: 8 STOPs with ready low; 7 accepted, 4 buffered
    new_frame(19'd1000);
    hit(1'b1, 16'hFF00, 14'd0);
    for (int k = 1; k <= 8; k++) hit(1'b0, 16'hFF00, 14'(k));
    idle(10);
    check("ovf_cnt0", 32'(hc0), 32'd7);
    check("ovf_cnt1", 32'(hc1), 32'd7);
    check("ovf_err0", 32'(e0), 32'd5);
    check("ovf_err1", 32'(e1), 32'd5);
    for (int k = 1; k <= 4; k++)
      pop_chk("ovf_pop", 19'(16 * k), 19'(16 * k), 3'(k), 1'b0);
    check("ovf_drained", 32'(v0 | v1), 32'd0);

    // Bubble code: ones-count gives 10, highest-edge decode gives 5
    new_frame(19'd1000);
    hit(1'b1, 16'h0000, 14'd20);
    hit(1'b0, 16'b0000_0110_1111_1111, 14'd20);
    wait_res("bubble");
    pop_chk("bubble", 19'd5, 19'd10, 3'd1, 1'b0);

    // Reset with a buffered result, a sticky error and 3 hits in flight
    new_frame(19'd1000);
    hit(1'b0, 16'hFF00, 14'd0);
    hit(1'b1, 16'hFF00, 14'd0);
    hit(1'b0, 16'hFF00, 14'd1);
    wait_res("pre_rst");
    check("pre_rst_err", 32'(e0), 32'd2);
    hit(1'b0, 16'hFF00, 14'd2);
    hit(1'b0, 16'hFF00, 14'd3);
    hit(1'b0, 16'hFF00, 14'd4);
    rst = 1'b1;
    #2;
    check("mid_rst_valid", 32'(v0 | v1), 32'd0);
    check("mid_rst_data",  32'(d0 | d1 | 19'(i0) | 19'(i1)), 32'd0);
    check("mid_rst_sat",   32'(s0 | s1), 32'd0);
    check("mid_rst_cnt",   32'(hc0 | hc1), 32'd0);
    check("mid_rst_err",   32'(e0 | e1), 32'd0);
    cyc();
    rst = 1'b0;
    idle(10);
    check("post_rst_nores", 32'(v0 | v1), 32'd0);
    hit(1'b0, 16'hFF00, 14'd5);
    cyc();
    check("idle_stop_err0", 32'(e0), 32'd2);
    check("idle_stop_err1", 32'(e1), 32'd2);
    idle(10);
    check("idle_nores", 32'(v0 | v1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
